// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample feeder.
package i2s_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int UNDERRUN_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_sample_feeder_if.sv
// CPU-side write port of the I2S sample feeder: push strobe, data, and FIFO status.
interface i2s_sample_feeder_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
);

  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     full;
  logic [$clog2(DEPTH):0]   level;

  modport master (output wr_en, wr_data, input full, level);
  modport slave  (input wr_en, wr_data, output full, level);

endinterface

// File: rtl/i2s_sample_feeder_fifo.sv
// Single-clock sample FIFO (sample_fifo); DEPTH must be a power of two so pointers wrap naturally.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2s_sample_feeder.sv
// Feeds the I2S transmitter's value input from a sample FIFO, one sample per lrclk slot.
// Build option: I2S_FEEDER_HOLD_EN holds the last played sample during underrun/PRIME.
module i2s_sample_feeder
  import i2s_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 8,
  parameter int WIDTH       = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  i2s_sample_feeder_if.slave    cpu,
  input  logic                  lrclk,
  output logic [WIDTH-1:0]      value,
  output logic                  running,
  output logic [7:0]            underrun_cnt,
  output logic                  overflow,
  input  logic                  clr_flags
);

  localparam int LW = $clog2(DEPTH) + 1;
`ifdef I2S_FEEDER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  state_t           state, state_nxt;
  logic             lr_q, lr_edge, lr_fall;
  logic [WIDTH-1:0] head, value_nxt;
  logic [LW-1:0]    level;
  logic             full, empty, pop, underrun_evt, start_ok;

  assign lr_edge   = lrclk ^ lr_q;
  assign lr_fall   = lr_edge & ~lrclk;
  assign start_ok  = (level >= LW'(START_LEVEL));
  assign cpu.full  = full;
  assign cpu.level = level;

  sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu.wr_en),
    .pop   (pop),
    .din   (cpu.wr_data),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lr_q  <= 1'b0;
      value <= '0;
    end else begin
      state <= state_nxt;
      lr_q  <= lrclk;
      value <= value_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (lr_fall && start_ok) state_nxt = RUN;
        RUN:     if (lr_edge && empty) state_nxt = PRIME;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pop and value load happen in the same cycle the slot edge is seen.
  always_comb begin
    pop          = 1'b0;
    underrun_evt = 1'b0;
    value_nxt    = value;
    running      = (state == RUN);
    if (!enable) begin
      value_nxt = '0;
    end else begin
      case (state)
        IDLE: value_nxt = '0;
        PRIME: begin
          if (!HOLD) value_nxt = '0;
          if (lr_fall && start_ok) begin
            pop       = 1'b1;
            value_nxt = head;
          end
        end
        RUN: begin
          if (lr_edge) begin
            if (!empty) begin
              pop       = 1'b1;
              value_nxt = head;
            end else begin
              underrun_evt = 1'b1;
              if (!HOLD) value_nxt = '0;
            end
          end
        end
        default: value_nxt = '0;
      endcase
    end
  end

  // A new event in the same cycle as clr_flags takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (underrun_evt) begin
        if (clr_flags)                           underrun_cnt <= 8'd1;
        else if (underrun_cnt != 8'(UNDERRUN_MAX)) underrun_cnt <= underrun_cnt + 8'd1;
      end else if (clr_flags) begin
        underrun_cnt <= '0;
      end
      if (cpu.wr_en && full) overflow <= 1'b1;
      else if (clr_flags)    overflow <= 1'b0;
    end
  end

endmodule
